fully_pipelined_adder_checker: RTL and testbench
================================================

Name: fully_pipelined_adder_checker

Overview:
- Result-side companion to fully_pipelined_adder. The operand driver launches a, b, c into the adder; this block captures the same operands at launch and computes the golden {carry,s}.
- It delays that golden value through an en-gated shadow pipeline matched to the adder latency. It then compares against the adder outputs and keeps pass/fail statistics.
- Used in benches and as an on-chip self-test monitor.

Parameters:
- WIDTH, 3, operand width; must match the adder's WIDTH.
- LATENCY, WIDTH, adder latency in enabled clocks; must be >= 1.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  in  1  rising-edge clock shared with the adder.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately.
- en  in  1  pipeline enable, same net as the adder's en.
- issue  in  1  operands on a/b/c are being launched into the adder this edge.
- a  in  WIDTH  operand A as launched.
- b  in  WIDTH  operand B as launched.
- c  in  1  carry-in as launched.
- s  in  WIDTH  adder sum output.
- carry  in  1  adder carry output.
- clear  in  1  synchronous clear of counters and sticky flag.
- check_valid  out  1  one-cycle pulse: a comparison result is presented.
- check_pass  out  1  result of that comparison (1 = match).
- expected  out  WIDTH+1  golden {carry,s} of the checked op.
- observed  out  WIDTH+1  adder {carry,s} captured for the checked op.
- mismatch  out  1  sticky: at least one failed check since reset/clear.
- pass_count  out  CNT_W  saturating count of passed checks.
- fail_count  out  CNT_W  saturating count of failed checks.

Behaviour:
- Reset (rst=0, async): all shadow-stage valid bits cleared; pending entries are discarded, not checked. All outputs are 0.
- Golden value: gold = a + b + c, computed at full WIDTH+1 width; bit WIDTH is the expected carry. No truncation before compare.
- Shadow pipeline: LATENCY stages, each holding {vld, gold[WIDTH:0]}.
  - On a rising edge with en=1: stage0 <= {issue, gold}; stage[k] <= stage[k-1].
  - With en=0: all stages hold and issue is ignored. The adder does not sample operands either.
- Alignment: an op issued at enabled edge n sits in stage[LATENCY-1] after edge n+LATENCY-1. During that same cycle the adder presents its result on {carry,s}.
- Check edge: the next rising edge with en=1 and stage[LATENCY-1].vld=1 does the following.
  - check_valid <= 1.
  - expected <= stage gold.
  - observed <= {carry,s}.
  - check_pass <= (gold == {carry,s}).
  - On a match, pass_count increments; otherwise fail_count increments and mismatch <= 1.
- Check latency: with en held at 1, an op issued at edge n produces check_valid high for exactly the cycle after edge n+LATENCY.
- Edges with no check: check_valid <= 0. check_pass, expected and observed hold their last values.
- en=0 during the check cycle: no check is made and the entry stays in place. It is checked at the next enabled edge against the then-current {carry,s}, which the adder also held.
- Back-to-back issue on every enabled edge yields one check per enabled edge, with no bubbles and no loss.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clear=1 at a rising edge:
  - pass_count, fail_count and mismatch go to 0.
  - The shadow pipeline is untouched.
  - A check on the same edge is still reported on check_valid/check_pass but is not counted and does not set mismatch (clear wins).
- Reset mid-operation: in-flight ops are lost. After rst releases, the first check corresponds to the first op issued after reset.

Test Plan:
- WIDTH=3, en=1, issue (a,b,c) = (0,2,0), (1,1,1), (2,3,0) on consecutive edges -> three check_valid pulses on consecutive cycles, starting the cycle after issue edge+3. Expected = 2, 3, 5; all pass; pass_count = 3; mismatch = 0.
- Overflow: (7,7,1) -> expected = 4'b1111 (carry=1, s=7); pass. Then (4,4,0) -> expected = 4'b1000; pass.
- Fault injection: force adder s to 0 for the op (1,2,0) -> check_pass = 0, expected = 3, observed = 0, fail_count = 1, mismatch = 1 and stays 1 across later passing checks.
- Stall: issue (3,3,0), then drop en for 4 cycles while the op is mid-pipe -> no check_valid during the stall. The check fires exactly LATENCY enabled edges after issue, with expected = 6.
- Saturation/clear: CNT_W=2, six passing ops -> pass_count sticks at 3. Pulse clear on the same edge as a failing check -> counters = 0 and mismatch = 0, with check_valid=1 and check_pass=0 reported.
- Reset mid-flight: issue two ops, assert rst=0 asynchronously between edges -> outputs go to 0 immediately. No checks follow for the dropped ops; a new op after release checks normally.

Source files
------------

// File: rtl/fully_pipelined_adder_checker.sv
// Result-side checker for fully_pipelined_adder: carries a golden {carry,s}
// through an en-gated shadow pipeline and compares it with the adder output.
module fully_pipelined_adder_checker #(
  parameter int WIDTH   = 3,
  parameter int LATENCY = WIDTH,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             issue,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic [WIDTH-1:0] s,
  input  logic             carry,
  input  logic             clear,
  output logic             check_valid,
  output logic             check_pass,
  output logic [WIDTH:0]   expected,
  output logic [WIDTH:0]   observed,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH:0]   gold_now;
  logic [WIDTH:0]   obs_now;
  logic [WIDTH:0]   stage_gold [LATENCY];
  logic [LATENCY-1:0] stage_vld;
  logic             do_check;
  logic             match;

  // Full WIDTH+1 sum so the carry bit is part of the golden value
  assign gold_now = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  assign obs_now  = {carry, s};
  assign do_check = en && stage_vld[LATENCY-1];
  assign match    = (stage_gold[LATENCY-1] == obs_now);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_vld[k]  <= 1'b0;
        stage_gold[k] <= '0;
      end
    end else if (en) begin
      stage_vld[0]  <= issue;
      stage_gold[0] <= gold_now;
      for (int k = 1; k < LATENCY; k++) begin
        stage_vld[k]  <= stage_vld[k-1];
        stage_gold[k] <= stage_gold[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      check_valid <= 1'b0;
      check_pass  <= 1'b0;
      expected    <= '0;
      observed    <= '0;
    end else begin
      check_valid <= do_check;
      if (do_check) begin
        check_pass <= match;
        expected   <= stage_gold[LATENCY-1];
        observed   <= obs_now;
      end
    end
  end

  // Clear takes priority over a same-edge check; counters saturate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
    end else if (do_check) begin
      if (match) begin
        if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
      end else begin
        mismatch <= 1'b1;
        if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fully_pipelined_adder_checker.sv
// Scoreboard bench for fully_pipelined_adder_checker with a behavioural
// stand-in adder whose result can be corrupted per operation.
module tb_fully_pipelined_adder_checker;

  localparam int W = 3;
  localparam int L = W;

  typedef struct {
    logic [W:0] exp_v;
    logic [W:0] obs_v;
    logic       pass_v;
    int         edge_v;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic issue = 1'b0;
  logic fault = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic c = 1'b0;
  logic [W-1:0] s;
  logic carry;

  logic check_valid, check_pass, mismatch;
  logic [W:0] expected, observed;
  logic [15:0] pass_count, fail_count;

  logic sat_valid, sat_pass, sat_mismatch;
  logic [W:0] sat_expected, sat_observed;
  logic [1:0] sat_pass_count, sat_fail_count;

  logic [W:0] apipe [L];
  logic       abad  [L];

  entry_t sb[$];
  int en_edges = 0;
  int compares = 0;
  int mismatches = 0;

  always #5 clk = ~clk;

  fully_pipelined_adder_checker #(.WIDTH(W), .LATENCY(L), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .issue(issue), .a(a), .b(b), .c(c),
    .s(s), .carry(carry), .clear(clear),
    .check_valid(check_valid), .check_pass(check_pass),
    .expected(expected), .observed(observed), .mismatch(mismatch),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  fully_pipelined_adder_checker #(.WIDTH(W), .LATENCY(L), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .issue(issue), .a(a), .b(b), .c(c),
    .s(s), .carry(carry), .clear(clear),
    .check_valid(sat_valid), .check_pass(sat_pass),
    .expected(sat_expected), .observed(sat_observed), .mismatch(sat_mismatch),
    .pass_count(sat_pass_count), .fail_count(sat_fail_count)
  );

  // Stand-in adder: LATENCY enabled clocks, output forced to 0 for faulted ops
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < L; k++) begin
        apipe[k] <= '0;
        abad[k]  <= 1'b0;
      end
    end else if (en) begin
      apipe[0] <= {1'b0, a} + b + c;
      abad[0]  <= issue && fault;
      for (int k = 1; k < L; k++) begin
        apipe[k] <= apipe[k-1];
        abad[k]  <= abad[k-1];
      end
    end
  end

  assign {carry, s} = abad[L-1] ? '0 : apipe[L-1];

  always @(posedge clk) begin
    if (rst && en) en_edges <= en_edges + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compares++;
    if (actual !== required) begin
      mismatches++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Monitor: pops the scoreboard whenever the checker presents a result
  always @(negedge clk) begin
    if (rst && check_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_check", 1, 0);
      end else begin
        entry_t e;
        e = sb.pop_front();
        checkOutput("expected", expected, e.exp_v);
        checkOutput("observed", observed, e.obs_v);
        checkOutput("check_pass", check_pass, e.pass_v);
        checkOutput("check_edge", en_edges, e.edge_v);
        checkOutput("sat_check_pass", sat_pass, e.pass_v);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic fv,
                               input logic [W:0] exp_v);
    entry_t e;
    issue = 1'b1;
    a = av;
    b = bv;
    c = cv;
    fault = fv;
    e.exp_v  = exp_v;
    e.obs_v  = fv ? '0 : exp_v;
    e.pass_v = !fv;
    e.edge_v = en_edges + 1 + L;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    issue = 1'b0;
    fault = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_check_valid"}, check_valid, 0);
    checkOutput({tag, "_check_pass"}, check_pass, 0);
    checkOutput({tag, "_expected"}, expected, 0);
    checkOutput({tag, "_observed"}, observed, 0);
    checkOutput({tag, "_mismatch"}, mismatch, 0);
    checkOutput({tag, "_pass_count"}, pass_count, 0);
    checkOutput({tag, "_fail_count"}, fail_count, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkZero("reset");
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);

    applyStimulus(3'd0, 3'd2, 1'b0, 1'b0, 4'd2);
    applyStimulus(3'd1, 3'd1, 1'b1, 1'b0, 4'd3);
    applyStimulus(3'd2, 3'd3, 1'b0, 1'b0, 4'd5);
    idle(5);
    checkOutput("basic_pass_count", pass_count, 3);
    checkOutput("basic_fail_count", fail_count, 0);
    checkOutput("basic_mismatch", mismatch, 0);

    applyStimulus(3'd7, 3'd7, 1'b1, 1'b0, 4'b1111);
    applyStimulus(3'd4, 3'd4, 1'b0, 1'b0, 4'b1000);
    idle(5);
    checkOutput("ovf_pass_count", pass_count, 5);

    applyStimulus(3'd1, 3'd2, 1'b0, 1'b1, 4'd3);
    idle(1);
    applyStimulus(3'd1, 3'd0, 1'b0, 1'b0, 4'd1);
    idle(5);
    checkOutput("fault_fail_count", fail_count, 1);
    checkOutput("fault_mismatch_sticky", mismatch, 1);
    checkOutput("fault_pass_count", pass_count, 6);
    checkOutput("sat_pass_count", sat_pass_count, 3);
    checkOutput("sat_fail_count", sat_fail_count, 1);

    applyStimulus(3'd3, 3'd3, 1'b0, 1'b0, 4'd6);
    idle(1);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    idle(6);
    checkOutput("stall_pass_count", pass_count, 7);

    applyStimulus(3'd2, 3'd2, 1'b0, 1'b1, 4'd4);
    issue = 1'b0;
    fault = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_check_valid", check_valid, 1);
    checkOutput("clear_check_pass", check_pass, 0);
    checkOutput("clear_pass_count", pass_count, 0);
    checkOutput("clear_fail_count", fail_count, 0);
    checkOutput("clear_mismatch", mismatch, 0);
    checkOutput("clear_sat_pass_count", sat_pass_count, 0);
    checkOutput("clear_sat_fail_count", sat_fail_count, 0);
    idle(3);

    applyStimulus(3'd5, 3'd1, 1'b0, 1'b0, 4'd6);
    applyStimulus(3'd6, 3'd6, 1'b1, 1'b0, 4'd13);
    issue = 1'b0;
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    checkZero("midreset");
    @(negedge clk);
    rst = 1'b1;
    idle(6);
    applyStimulus(3'd2, 3'd1, 1'b1, 1'b0, 4'd4);
    idle(5);
    checkOutput("post_reset_pass_count", pass_count, 1);
    checkOutput("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
